// File: rtl/result_display_if.sv
// Signal bundle between the compute core / board pins and result_display.
//
// Handshake: done is a single-cycle strobe with no back-pressure. The
// x_result, y_result and k_mode_in inputs are valid only in the cycle where
// done is high. result_display always accepts the strobe, so there is no
// ready signal. btn_sel is a debounced level, and seg/an/dp/led_* are
// free-running display outputs. dbg_state mirrors the display FSM
// (0 = EMPTY, 1 = SHOW_X, 2 = SHOW_Y).
interface result_display_if;
   logic        done;
   logic [15:0] x_result;
   logic [15:0] y_result;
   logic        k_mode_in;
   logic        btn_sel;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        dp;
   logic        led_valid;
   logic        led_k;
   logic [1:0]  dbg_state;

   // Core / board side
   modport master (
      output done, x_result, y_result, k_mode_in, btn_sel,
      input  seg, an, dp, led_valid, led_k, dbg_state
   );

   // Display block side
   modport slave (
      input  done, x_result, y_result, k_mode_in, btn_sel,
      output seg, an, dp, led_valid, led_k, dbg_state
   );
endinterface

// File: rtl/result_display.sv
// Result display: captures X/Y/K_mode on done and shows either X or Y on a
// 4-digit multiplexed active-low seven-segment display. A rising edge on the
// select button toggles between X and Y once data exists. The segment,
// anode and decimal-point outputs are registered from the current state.
module result_display #(
   parameter int REFRESH_DIV = 1000
) (
   input logic             clk,
   input logic             reset,
   result_display_if.slave bus
);

   localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [6:0] SEG_DASH = 7'b0111111;

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      SHOW_X = 2'd1,
      SHOW_Y = 2'd2
   } state_t;

   state_t        state;
   logic [15:0]   x_q;
   logic [15:0]   y_q;
   logic          k_q;
   logic          valid_q;
   logic          btn_sel_d;
   logic [CW-1:0] ref_cnt;
   logic [1:0]    dig;
   logic [6:0]    seg_q;
   logic [3:0]    an_q;
   logic          dp_q;

   logic          btn_edge;
   logic [15:0]   sel_val;
   logic [3:0]    nibble;
   logic [6:0]    hex_seg;
   logic [6:0]    next_seg;
   logic [3:0]    next_an;
   logic          next_dp;

   assign btn_edge = bus.btn_sel & ~btn_sel_d;
   assign sel_val  = (state == SHOW_Y) ? y_q : x_q;
   assign nibble   = sel_val[{dig, 2'b00} +: 4];
   assign next_seg = (state == EMPTY) ? SEG_DASH : hex_seg;
   assign next_an  = ~(4'b0001 << dig);
   assign next_dp  = ~((state == SHOW_Y) && (dig == 2'd3));

   // Hex nibble to active-low {g,f,e,d,c,b,a} segment pattern
   always_comb begin
      hex_seg = 7'b1111111;
      case (nibble)
         4'h0: hex_seg = 7'b1000000;
         4'h1: hex_seg = 7'b1111001;
         4'h2: hex_seg = 7'b0100100;
         4'h3: hex_seg = 7'b0110000;
         4'h4: hex_seg = 7'b0011001;
         4'h5: hex_seg = 7'b0010010;
         4'h6: hex_seg = 7'b0000010;
         4'h7: hex_seg = 7'b1111000;
         4'h8: hex_seg = 7'b0000000;
         4'h9: hex_seg = 7'b0010000;
         4'hA: hex_seg = 7'b0001000;
         4'hB: hex_seg = 7'b0000011;
         4'hC: hex_seg = 7'b1000110;
         4'hD: hex_seg = 7'b0100001;
         4'hE: hex_seg = 7'b0000110;
         4'hF: hex_seg = 7'b0001110;
         default: hex_seg = 7'b1111111;
      endcase
   end

   // Display FSM, result capture, digit scan and registered display outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= EMPTY;
         x_q       <= '0;
         y_q       <= '0;
         k_q       <= 1'b0;
         valid_q   <= 1'b0;
         btn_sel_d <= 1'b0;
         ref_cnt   <= '0;
         dig       <= 2'd0;
         seg_q     <= SEG_DASH;
         an_q      <= 4'b1110;
         dp_q      <= 1'b1;
      end else begin
         btn_sel_d <= bus.btn_sel;

         if (bus.done) begin
            x_q     <= bus.x_result;
            y_q     <= bus.y_result;
            k_q     <= bus.k_mode_in;
            valid_q <= 1'b1;
         end

         // A button edge and done in the same cycle both act; from EMPTY
         // only done matters and it always lands in SHOW_X.
         case (state)
            EMPTY:   if (bus.done) state <= SHOW_X;
            SHOW_X:  if (btn_edge) state <= SHOW_Y;
            SHOW_Y:  if (btn_edge) state <= SHOW_X;
            default: state <= EMPTY;
         endcase

         if (ref_cnt == REF_LAST) begin
            ref_cnt <= '0;
            dig     <= dig + 2'd1;
         end else begin
            ref_cnt <= ref_cnt + 1'b1;
         end

         seg_q <= next_seg;
         an_q  <= next_an;
         dp_q  <= next_dp;
      end
   end

   assign bus.seg       = seg_q;
   assign bus.an        = an_q;
   assign bus.dp        = dp_q;
   assign bus.led_valid = valid_q;
   assign bus.led_k     = k_q;
   assign bus.dbg_state = state;

endmodule

// File: tb/tb_result_display.sv
// Bench for result_display: directed scenarios with literal expectations
// plus a randomized phase checked every cycle against a frame-arithmetic
// model of the display.
module tb_result_display;

   localparam int DIV = 4;

   logic clk;
   logic reset;

   result_display_if bus ();

   result_display #(.REFRESH_DIV(DIV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- counters / check ----------------
   int n_vec  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Segment table for hex digits 0..F (active-low {g..a})
   logic [6:0] hex_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   // ---------------- reference model ----------------
   // m_mode: 0 = nothing captured, 1 = showing X, 2 = showing Y.
   // m_n counts clock edges since reset; the active digit is the frame
   // position (m_n / DIV) mod 4. The e_* values are what the outputs must
   // read after the current edge.
   int          m_mode;
   int          m_n;
   int          m_dig;
   logic [15:0] m_x, m_y, m_v;
   logic        m_k, m_valid, m_btn_prev, m_edge;
   logic [6:0]  e_seg;
   logic [3:0]  e_an;
   logic        e_dp;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_mode = 0; m_n = 0; m_x = '0; m_y = '0; m_k = 1'b0;
         m_valid = 1'b0; m_btn_prev = 1'b0;
         e_seg = 7'b0111111; e_an = 4'b1110; e_dp = 1'b1;
      end else begin
         m_dig = (m_n / DIV) % 4;
         if (m_mode == 0) e_seg = 7'b0111111;
         else begin
            m_v   = (m_mode == 1) ? m_x : m_y;
            e_seg = hex_tab[(m_v >> (4 * m_dig)) & 16'hF];
         end
         e_an = 4'hF ^ (4'h1 << m_dig);
         e_dp = !(m_mode == 2 && m_dig == 3);
         m_edge = bus.btn_sel && !m_btn_prev;
         m_btn_prev = bus.btn_sel;
         if (m_mode == 0) begin
            if (bus.done) m_mode = 1;
         end else if (m_edge) m_mode = 3 - m_mode;
         if (bus.done) begin
            m_x = bus.x_result; m_y = bus.y_result; m_k = bus.k_mode_in; m_valid = 1'b1;
         end
         m_n = (m_n + 1) % (4 * DIV);
      end
   end

   // ---------------- compare process ----------------
   logic started = 1'b0;
   always @(negedge clk) begin
      if (started) begin
         check("seg", {9'd0, bus.seg}, {9'd0, e_seg});
         check("an", {12'd0, bus.an}, {12'd0, e_an});
         check("dp", {15'd0, bus.dp}, {15'd0, e_dp});
         check("led_valid", {15'd0, bus.led_valid}, {15'd0, m_valid});
         check("led_k", {15'd0, bus.led_k}, {15'd0, m_k});
         check("state", {14'd0, bus.dbg_state}, 16'(m_mode));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic pulse_done(input logic [15:0] x, input logic [15:0] y, input logic k,
                             input logic with_btn);
      @(negedge clk);
      bus.done = 1'b1; bus.x_result = x; bus.y_result = y; bus.k_mode_in = k;
      if (with_btn) bus.btn_sel = 1'b1;
      @(negedge clk);
      bus.done = 1'b0;
      if (with_btn) bus.btn_sel = 1'b0;
   endtask

   task automatic hold_btn(input int cycles);
      @(negedge clk);
      bus.btn_sel = 1'b1;
      repeat (cycles) @(negedge clk);
      bus.btn_sel = 1'b0;
   endtask

   // Wait (bounded) for a given anode pattern; leaves us on that negedge.
   task automatic wait_an(input logic [3:0] target);
      int i;
      for (i = 0; i < 6 * DIV; i++) begin
         @(negedge clk);
         if (bus.an == target) break;
      end
      if (bus.an != target) begin
         n_vec++; n_fail++;
         $display("FAIL wait_an: timeout, got %b expected %b", bus.an, target);
      end
   endtask

   // Walk digits 0..3 checking literal segment and dp values.
   task automatic check_digits(input string name, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3, input logic dp3);
      logic [3:0] an_seq [4];
      logic [6:0] seg_seq [4];
      an_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      seg_seq = '{s0, s1, s2, s3};
      for (int d = 0; d < 4; d++) begin
         wait_an(an_seq[d]);
         check(name, {9'd0, bus.seg}, {9'd0, seg_seq[d]});
         check({name, "_dp"}, {15'd0, bus.dp}, (d == 3) ? {15'd0, dp3} : 16'd1);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [3:0] lit_an [4];
      lit_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      bus.done = 1'b0; bus.x_result = '0; bus.y_result = '0;
      bus.k_mode_in = 1'b0; bus.btn_sel = 1'b0;
      reset = 1'b1;
      #1 started = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_seg", {9'd0, bus.seg}, 16'h003F);
      check("rst_an", {12'd0, bus.an}, 16'h000E);
      check("rst_dp", {15'd0, bus.dp}, 16'd1);
      check("rst_led_valid", {15'd0, bus.led_valid}, 16'd0);
      reset = 1'b0;

      // Empty scan: anodes rotate every DIV cycles, dashes throughout
      for (int k = 1; k <= 4 * DIV; k++) begin
         @(negedge clk);
         check("scan_an", {12'd0, bus.an}, {12'd0, lit_an[(k - 1) / DIV]});
         check("scan_seg", {9'd0, bus.seg}, 16'h003F);
      end

      // Button in EMPTY is ignored
      hold_btn(2);
      hold_btn(3);
      repeat (3) @(negedge clk);
      check("empty_btn_state", {14'd0, bus.dbg_state}, 16'd0);
      check("empty_btn_seg", {9'd0, bus.seg}, 16'h003F);

      // Capture 1234 / FFF0 with K_mode
      pulse_done(16'h1234, 16'hFFF0, 1'b1, 1'b0);
      check("cap_led_valid", {15'd0, bus.led_valid}, 16'd1);
      check("cap_led_k", {15'd0, bus.led_k}, 16'd1);
      check("cap_state", {14'd0, bus.dbg_state}, 16'd1);
      check_digits("cap_x", 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 1'b1);

      // Held button toggles exactly once
      hold_btn(20);
      check("hold_state", {14'd0, bus.dbg_state}, 16'd2);
      check_digits("show_y", 7'b1000000, 7'b0001110, 7'b0001110, 7'b0001110, 1'b0);

      // done and button edge together in SHOW_Y
      pulse_done(16'h00AB, 16'h0010, 1'b0, 1'b1);
      check("simul_state", {14'd0, bus.dbg_state}, 16'd1);
      check("simul_led_k", {15'd0, bus.led_k}, 16'd0);
      check_digits("simul_x", 7'b0000011, 7'b0001000, 7'b1000000, 7'b1000000, 1'b1);
      hold_btn(1);
      check_digits("simul_y", 7'b1000000, 7'b1111001, 7'b1000000, 7'b1000000, 1'b0);

      // Asynchronous reset mid-frame while digit 2 of Y is shown
      wait_an(4'b1011);
      #2 reset = 1'b1;
      #1;
      check("arst_seg", {9'd0, bus.seg}, 16'h003F);
      check("arst_an", {12'd0, bus.an}, 16'h000E);
      check("arst_dp", {15'd0, bus.dp}, 16'd1);
      check("arst_led_valid", {15'd0, bus.led_valid}, 16'd0);
      check("arst_led_k", {15'd0, bus.led_k}, 16'd0);
      check("arst_state", {14'd0, bus.dbg_state}, 16'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_an", {12'd0, bus.an}, 16'h000E);
      check("post_rst_seg", {9'd0, bus.seg}, 16'h003F);

      // Randomized phase, checked by the compare process
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         bus.done      = ($urandom_range(0, 9) == 0);
         bus.x_result  = 16'($urandom);
         bus.y_result  = 16'($urandom);
         bus.k_mode_in = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 5) == 0) bus.btn_sel = ~bus.btn_sel;
         if ($urandom_range(0, 299) == 0) begin
            #2 reset = 1'b1;
            #3 reset = 1'b0;
         end
      end
      @(negedge clk);
      bus.done = 1'b0;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   // Watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/result_display.md
# result_display

Output-side user interface for the compute datapath. It captures the signed X/Y results and the K_mode flag when the core signals completion. It presents one result at a time on a 4-digit, multiplexed, active-low seven-segment display and on status LEDs, and a debounced-upstream button selects which result is shown. It is the counterpart of the switch/button input-capture stage: that stage feeds operands in, and this block shows results out.

## Interface
- REFRESH_DIV, default 1000: clock cycles each digit stays active; legal range ≥ 2.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- done  input  1  single-cycle pulse from the core; results are valid in that cycle.
- x_result  input  16  signed X result (two's complement).
- y_result  input  16  signed Y result (two's complement).
- k_mode_in  input  1  K_mode value in effect for the completed operation.
- btn_sel  input  1  level from the button; a rising edge toggles the displayed result.
- seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
- an  output  4  digit enables, active-low, one-hot; an[0] is the least-significant nibble.
- dp  output  1  decimal point, active-low.
- led_valid  output  1  high once any result has been captured.
- led_k  output  1  captured K_mode.

## Operation
- State machine with three states: EMPTY (reset state), SHOW_X, SHOW_Y.
  - EMPTY → SHOW_X on done.
  - SHOW_X ↔ SHOW_Y on a btn_sel rising edge.
  - A btn_sel edge in EMPTY is ignored.
  - done in SHOW_X or SHOW_Y recaptures the data and keeps the current state.
- Capture: on done, register x_result, y_result and k_mode_in; set led_valid = 1.
- Edge detect: btn_sel is delayed one register; an edge is btn_sel & ~btn_sel_d. A held button toggles exactly once.
- If done and a btn_sel edge occur in the same cycle, both take effect: new data is captured and the state toggles. From EMPTY the state goes only to SHOW_X.
- Scan counter:
  - ref_cnt counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit index dig advances 0→1→2→3→0.
- Display content:
  - In EMPTY, every digit shows a dash: 7'b0111111.
  - Otherwise, digit dig shows hex nibble [4·dig+3 : 4·dig] of the selected register, raw two's complement.
- Hex encoding, active-low {g..a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- dp = 0 only when state is SHOW_Y and dig = 3; otherwise dp = 1.
- led_k follows the captured flag, not k_mode_in live.
- Reset asserted at any time returns everything to reset values immediately. There is no partial retention.

## Timing
- Reset values:
  - state = EMPTY, ref_cnt = 0, dig = 0.
  - seg = 7'b0111111, an = 4'b1110, dp = 1.
  - led_valid = 0, led_k = 0, captured registers = 0, btn_sel_d = 0.
- seg, an and dp are registered, computed from the current state, dig and captured data. They lag internal changes by one cycle.
- done high in cycle t: the registers are updated at the edge ending t, and seg/an/dp reflect the new data at the following edge (visible in t+2).
- btn_sel rising in cycle t: the state toggles at the edge ending t, and the display reflects it in t+2.
- Each digit stays active for exactly REFRESH_DIV cycles. The full frame is 4·REFRESH_DIV cycles.
- led_valid and led_k have 1-cycle latency from done. They are not delayed by the display pipeline.

## Test plan
- Reset with REFRESH_DIV=4:
  - Required: an cycles 1110→1101→1011→0111 every 4 cycles, seg = 0111111 throughout, led_valid = 0, dp = 1.
- Capture:
  - Stimulus: done with x_result=16'h1234, y_result=16'hFFF0, k_mode_in=1.
  - Required: SHOW_X; digits 0..3 show 4,3,2,1 (0011001, 0110000, 0100100, 1111001); led_valid = 1 and led_k = 1 one cycle after done; dp always 1.
- Select toggle, from the capture state:
  - Stimulus: btn_sel held high for 20 cycles.
  - Required: exactly one toggle to SHOW_Y; digits show 0,F,F,F (1000000, 0001110, 0001110, 0001110); dp = 0 only while an = 0111.
- Button before data:
  - Stimulus: btn_sel pulses in EMPTY.
  - Required: state stays EMPTY and dashes remain. A later done enters SHOW_X.
- Simultaneous events in SHOW_Y:
  - Stimulus: done with x=16'h00AB, y=16'h0010 in the same cycle as a btn_sel edge.
  - Required: SHOW_X displaying B,A,0,0; the y register holds 16'h0010.
- Reset mid-frame:
  - Stimulus: assert reset asynchronously between clock edges while in SHOW_Y with dig = 2.
  - Required: outputs return to reset values without waiting for a clock edge. After release, dashes and an = 1110 are shown.
